// File: rtl/spi_frame_loader.sv
// SPI mode-0 slave that streams a command-prefixed frame into the matrix frame buffer.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before frame_done.
module spi_frame_loader #(
  parameter int         BYTES_TOTAL = 192,
  parameter logic [7:0] CMD_WRITE   = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic [8:0] address_out,
  output logic [7:0] data_out,
  output logic       write_strobe_out,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_CSUM    = 3'd3;
  localparam logic [2:0] S_DISCARD = 3'd4;
  localparam logic [8:0] LAST_IDX  = 9'(BYTES_TOTAL - 1);

  logic       r_sck_s1, r_sck_s2, r_sck_h;
  logic       r_cs_s1, r_cs_s2, r_cs_h;
  logic       r_mosi_s1, r_mosi_s2, r_mosi_h;
  logic [1:0] r_sync_vld;
  logic       r_cs_armed;
  logic [2:0] r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [8:0] r_index;
  logic [8:0] r_addr;
  logic [7:0] r_data;
  logic       r_strobe;
  logic       r_done;

  logic       w_sck_rise, w_cs_fall, w_cs_rise;
  logic [7:0] w_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_s1   <= 1'b0; r_sck_s2  <= 1'b0; r_sck_h  <= 1'b0;
      r_cs_s1    <= 1'b1; r_cs_s2   <= 1'b1; r_cs_h   <= 1'b1;
      r_mosi_s1  <= 1'b0; r_mosi_s2 <= 1'b0; r_mosi_h <= 1'b0;
      r_sync_vld <= 2'b00;
      r_cs_armed <= 1'b0;
    end else begin
      r_sck_s1   <= spi_sck;  r_sck_s2  <= r_sck_s1;  r_sck_h  <= r_sck_s2;
      r_cs_s1    <= spi_cs_n; r_cs_s2   <= r_cs_s1;   r_cs_h   <= r_cs_s2;
      r_mosi_s1  <= spi_mosi; r_mosi_s2 <= r_mosi_s1; r_mosi_h <= r_mosi_s2;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      // After reset, a chip select still held low must not look like a fresh falling edge.
      if (r_sync_vld[1] && r_cs_s2)
        r_cs_armed <= 1'b1;
    end
  end

  assign w_sck_rise = r_sck_s2 & ~r_sck_h;
  assign w_cs_fall  = r_cs_armed & r_cs_h & ~r_cs_s2;
  assign w_cs_rise  = r_cs_s2 & ~r_cs_h;
  // mosi history holds the sample taken just before sck was seen high: mid setup window.
  assign w_byte     = {r_shift, r_mosi_h};

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 7'd0;
      r_index   <= 9'd0;
      r_addr    <= 9'd0;
      r_data    <= 8'd0;
      r_strobe  <= 1'b0;
      r_done    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum    <= 8'd0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_err    <= 1'b0;
`endif
      if (w_cs_rise) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 3'd0;
      end else if (w_cs_fall) begin
        r_state   <= S_CMD;
        r_bit_cnt <= 3'd0;
        r_index   <= 9'd0;
`ifdef LOADER_CHECKSUM_EN
        r_csum    <= 8'd0;
`endif
      end else if (w_sck_rise && !r_cs_s2) begin
        r_shift   <= w_byte[6:0];
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          case (r_state)
            S_CMD: r_state <= (w_byte == CMD_WRITE) ? S_DATA : S_DISCARD;
            S_DATA: begin
              r_data   <= w_byte;
              r_addr   <= r_index;
              r_strobe <= 1'b1;
              r_index  <= r_index + 9'd1;
`ifdef LOADER_CHECKSUM_EN
              r_csum   <= r_csum ^ w_byte;
              if (r_index == LAST_IDX)
                r_state <= S_CSUM;
`else
              if (r_index == LAST_IDX) begin
                r_state <= S_DISCARD;
                r_done  <= 1'b1;
              end
`endif
            end
            S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
              if (w_byte == r_csum)
                r_done <= 1'b1;
              else
                r_err  <= 1'b1;
`endif
              r_state <= S_DISCARD;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign address_out      = r_addr;
  assign data_out         = r_data;
  assign write_strobe_out = r_strobe;
  assign frame_done       = r_done;
  assign busy             = (r_state != S_IDLE);
`ifdef LOADER_CHECKSUM_EN
  assign frame_err        = r_err;
`else
  assign frame_err        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed + randomized frames driven over SPI; strobes are captured and compared with a
// frame-level reference model computed from the byte stream sent.
module tb_spi_frame_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [8:0] address_out;
  logic [7:0] data_out;
  logic       write_strobe_out, frame_done, frame_err, busy;

  spi_frame_loader dut (
    .clk(clk), .rst(rst),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .address_out(address_out), .data_out(data_out),
    .write_strobe_out(write_strobe_out),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [16:0] cap_q[$];
  logic [16:0] exp_q[$];
  logic [7:0]  tx_q[$];
  int          cnt_done = 0, cnt_err = 0;
  int          exp_done, exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: capture every write, count completion pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (write_strobe_out) begin
        cap_q.push_back({address_out, data_out});
        check("addr_in_range", 32'(address_out < 9'd192), 32'd1);
      end
      if (frame_done) begin
        cnt_done++;
`ifndef LOADER_CHECKSUM_EN
        check("done_with_last_write", 32'({write_strobe_out, address_out}), 32'({1'b1, 9'd191}));
`endif
      end
      if (frame_err) cnt_err++;
    end
  end

  // Reference: command 0x01 then up to 192 payload bytes land at addresses 0..; completion
  // follows the 192nd byte (or the checksum byte when the checksum build is used).
  task automatic model();
    logic [7:0] acc;
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    acc      = 8'h00;
    if (tx_q.size() > 0 && tx_q[0] == 8'h01) begin
      for (int k = 1; k < tx_q.size() && k <= 192; k++) begin
        exp_q.push_back({9'(k - 1), tx_q[k]});
        acc = acc ^ tx_q[k];
      end
`ifdef LOADER_CHECKSUM_EN
      if (tx_q.size() > 193) begin
        if (tx_q[193] == acc) exp_done = 1;
        else                  exp_err  = 1;
      end
`else
      if (tx_q.size() > 192) exp_done = 1;
`endif
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      #20 spi_sck = 1'b1;
      #20 spi_sck = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input int partial);
    int max_addr;
    cap_q.delete();
    cnt_done = 0;
    cnt_err  = 0;
    spi_cs_n = 1'b0;
    #60;
    foreach (tx_q[i]) spi_bits(tx_q[i], 8);
    if (partial > 0) spi_bits(8'($urandom), partial);
    #40 spi_cs_n = 1'b1;
    #100;
    model();
    check({tag, "/n_strobes"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check({tag, "/write"}, 32'(cap_q[i]), 32'(exp_q[i]));
    check({tag, "/frame_done"}, 32'(cnt_done), 32'(exp_done));
    check({tag, "/frame_err"}, 32'(cnt_err), 32'(exp_err));
    check({tag, "/busy_idle"}, 32'(busy), 32'd0);
    max_addr = -1;
    foreach (cap_q[i]) if (int'(cap_q[i][16:8]) > max_addr) max_addr = int'(cap_q[i][16:8]);
    $display("frame %s: sent=%0d strobes=%0d done=%0d err=%0d max_addr=%0d",
             tag, tx_q.size(), cap_q.size(), cnt_done, cnt_err, max_addr);
    if (exp_q.size() == 192)
      check({tag, "/max_addr"}, 32'(max_addr), 32'd191);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] cmd;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst/address_out", 32'(address_out), 32'd0);
    check("rst/data_out", 32'(data_out), 32'd0);
    check("rst/write_strobe", 32'(write_strobe_out), 32'd0);
    check("rst/frame_done", 32'(frame_done), 32'd0);
    check("rst/frame_err", 32'(frame_err), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #50;

    // Sequential full frame
    tx_q.delete();
    tx_q.push_back(8'h01);
    for (int k = 0; k < 192; k++) tx_q.push_back(8'(k));
    run_frame("full_seq", 0);

    // Wrong command bytes
    tx_q.delete();
    tx_q.push_back(8'h02);
    repeat (10) tx_q.push_back(8'($urandom));
    run_frame("cmd_02", 0);
    cmd = 8'($urandom_range(3, 255));
    tx_q.delete();
    tx_q.push_back(cmd);
    repeat (6) tx_q.push_back(8'h01);
    run_frame("cmd_rand", 0);

    // Aborted mid-byte, then a random full frame that must restart at 0
    tx_q.delete();
    tx_q.push_back(8'h01);
    tx_q.push_back(8'hAA);
    run_frame("abort_5bits", 5);
    tx_q.delete();
    tx_q.push_back(8'h01);
    repeat (192) tx_q.push_back(8'($urandom));
    run_frame("full_rand", 0);

    // Random short frames with random trailing partial bits
    for (int f = 0; f < 3; f++) begin
      n = $urandom_range(1, 40);
      tx_q.delete();
      tx_q.push_back(8'h01);
      repeat (n) tx_q.push_back(8'($urandom));
      run_frame("short_rand", $urandom_range(0, 7));
    end

    // Reset mid-frame with chip select still low
    tx_q.delete();
    tx_q.push_back(8'h01);
    repeat (50) tx_q.push_back(8'($urandom));
    cap_q.delete();
    cnt_done = 0;
    spi_cs_n = 1'b0;
    #60;
    foreach (tx_q[i]) spi_bits(tx_q[i], 8);
    #60;
    model();
    check("pre_rst/n_strobes", 32'(cap_q.size()), 32'(exp_q.size()));
    cap_q.delete();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("mid_rst/busy", 32'(busy), 32'd0);
    spi_bits(8'h01, 8);
    repeat (9) spi_bits(8'($urandom), 8);
    #40 spi_cs_n = 1'b1;
    #100;
    check("post_rst_cs_low/n_strobes", 32'(cap_q.size()), 32'd0);
    check("post_rst_cs_low/frame_done", 32'(cnt_done), 32'd0);
    $display("frame mid_rst: strobes_after_reset=%0d done=%0d", cap_q.size(), cnt_done);
    tx_q.delete();
    tx_q.push_back(8'h01);
    repeat (192) tx_q.push_back(8'($urandom));
    run_frame("after_rst", 0);

    // Over-length frame
    tx_q.delete();
    tx_q.push_back(8'h01);
    repeat (200) tx_q.push_back(8'($urandom));
    run_frame("over_len", 0);

`ifdef LOADER_CHECKSUM_EN
    tx_q.delete();
    tx_q.push_back(8'h01);
    repeat (192) tx_q.push_back(8'h5A);
    tx_q.push_back(8'h00);
    run_frame("csum_good", 0);
    tx_q[193] = 8'h01;
    run_frame("csum_bad", 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_frame_loader.md
SPI_FRAME_LOADER -- requirements
Module: spi_frame_loader

Interface
REQ-001 Parameter BYTES_TOTAL, default 192, number of frame-buffer bytes per frame (3 boards x 16 columns x 4 rows).
REQ-002 Parameter CMD_WRITE, default 8'h01, command byte that opens a frame write.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 spi_sck  input  1  SPI clock, asynchronous to clk, mode 0.
REQ-006 spi_cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-007 spi_mosi  input  1  SPI data in, MSB first.
REQ-008 address_out  output  9  frame-buffer byte address, feeds matrix address_in.
REQ-009 data_out  output  8  frame-buffer byte value, feeds matrix data_in.
REQ-010 write_strobe_out  output  1  one-clk write pulse, feeds matrix write_strobe_in.
REQ-011 frame_done  output  1  one-clk pulse when a complete, valid frame has been written.
REQ-012 frame_err  output  1  one-clk pulse on checksum mismatch.
REQ-013 busy  output  1  high while state is not IDLE.

Function
REQ-014 spi_sck, spi_cs_n and spi_mosi SHALL each pass through a 2-FF synchronizer plus one history FF; edges are detected on the synchronized signals only.
REQ-015 Bits SHALL be shifted in MSB first on each detected sck rising edge while synchronized cs_n is low; a 3-bit counter marks byte completion on the 8th edge.
REQ-016 States: IDLE, CMD, DATA, CSUM, DISCARD.
REQ-017 A cs_n falling edge from any state SHALL clear the bit counter, the byte index and the checksum accumulator, and go to CMD.
REQ-018 CMD: a byte equal to CMD_WRITE goes to DATA; any other byte goes to DISCARD.
REQ-019 DATA: each completed byte SHALL drive data_out = byte, address_out = index, and write_strobe_out = 1 for exactly one clk, one clk after the completing edge is detected; the index then increments.
REQ-020 After the write at index BYTES_TOTAL-1, the block SHALL go to CSUM if LOADER_CHECKSUM_EN is defined, otherwise to DISCARD.
REQ-021 DISCARD: all further bytes are ignored with no strobes until cs_n rises.
REQ-022 A cs_n rising edge in any state SHALL drop any partial byte and go to IDLE; writes already issued are not rolled back.
REQ-023 An sck edge detected in the same clk as a cs_n rising edge SHALL be ignored.
REQ-024 address_out and data_out SHALL hold their last values between strobes.
REQ-025 The block SHALL never assert write_strobe_out with address_out >= BYTES_TOTAL.

Reset
REQ-026 On rst, all outputs SHALL be 0, the state SHALL be IDLE, and the counters, shift register and synchronizers SHALL be cleared (synchronizers to cs_n=1, sck=0).
REQ-027 rst asserted mid-frame SHALL abort the frame with no further strobes; the next frame requires a new cs_n falling edge.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN: when defined, the block XOR-accumulates all data bytes. In CSUM, the next byte is compared with the accumulator:
- equal: pulse frame_done, go to DISCARD;
- different: pulse frame_err, go to DISCARD.
REQ-029 Without LOADER_CHECKSUM_EN, frame_done SHALL pulse in the same clk as the final data write strobe, and frame_err SHALL be tied to 0.

Verification
REQ-030 Frame: CS low, 0x01, bytes 0x00..0xBF, CS high -> 192 strobes, address k carries data k, exactly one frame_done, busy back to 0.
REQ-031 Command 0x02 followed by 10 bytes -> zero strobes, no frame_done.
REQ-032 CS rises after 0x01, 0xAA and 5 bits of the next byte -> exactly one strobe (address 0, data 0xAA), no frame_done; the following frame starts again at address 0.
REQ-033 With LOADER_CHECKSUM_EN: 192 bytes of 0x5A plus checksum 0x00 -> frame_done; the same frame with checksum 0x01 -> frame_err and no frame_done.
REQ-034 rst pulsed after 50 data bytes, then a full frame -> no strobes between the reset and the new CS falling edge, then 192 correct writes.
REQ-035 Over-length frame of 200 data bytes (checksum macro undefined) -> exactly 192 strobes, and the highest address written is 191.
